// File: rtl/data_bus_demux_if.sv
// data_bus_demux_if
//   Groups the source stream and the two sink streams of data_bus_demux.
//   Handshake rule for every stream here: a word transfers on a rising clk
//   edge where valid && ready are both 1. The producer holds valid and its
//   payload steady until that edge. The consumer may drive ready freely.
//   ready seen without valid has no effect.
//   Signals:
//     in_valid/in_ready/in_data/in_sel        source stream (in_sel: 0 -> port 0, 1 -> port 1)
//     out0_valid/out0_ready/out0_data         sink port 0
//     out1_valid/out1_ready/out1_data         sink port 1
//   Modports:
//     slave  : the demux itself
//     master : the environment (source + sinks)
interface data_bus_demux_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_sel;
  logic        out0_valid;
  logic        out0_ready;
  logic [31:0] out0_data;
  logic        out1_valid;
  logic        out1_ready;
  logic [31:0] out1_data;

  modport slave (
    input  in_valid, in_data, in_sel, out0_ready, out1_ready,
    output in_ready, out0_valid, out0_data, out1_valid, out1_data
  );

  modport master (
    output in_valid, in_data, in_sel, out0_ready, out1_ready,
    input  in_ready, out0_valid, out0_data, out1_valid, out1_data
  );
endinterface

// File: rtl/data_bus_demux.sv
// data_bus_demux
//   Buffered 1-to-2 demultiplexer for 32-bit words. Words from the source
//   stream go into a DEPTH-entry FIFO together with their destination bit.
//   The head word is offered to the sink its bit selects, and words leave in
//   arrival order. A stalled head blocks every later word, whichever port
//   those words are for. Per-port counters record completed sink handshakes.
//   Parameters:
//     DEPTH  FIFO entries (power of 2, >= 2)
//     CNT_W  width of cnt0/cnt1
//   Ports:
//     clk   clock, rising edge
//     rst   asynchronous reset, active-high
//     bus   data_bus_demux_if.slave (source stream + two sink streams)
//     cnt0  completed port-0 handshakes, modulo 2^CNT_W
//     cnt1  completed port-1 handshakes, modulo 2^CNT_W
module data_bus_demux #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  data_bus_demux_if.slave    bus,
  output logic [CNT_W-1:0]   cnt0,
  output logic [CNT_W-1:0]   cnt1
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  // Each entry is {sel, data}.
  logic [32:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  logic        push;
  logic        pop;
  logic        pop0;
  logic        pop1;
  logic        nonempty;
  logic [32:0] head;

  assign nonempty = (count != '0);
  assign head     = mem[rd_ptr];

  // in_ready depends only on registered count and rst, so it has no path
  // from the sink readies. A pop in the same cycle does not open a slot.
  assign bus.in_ready = !rst && (count != FULL_CNT);
  assign push         = bus.in_valid && bus.in_ready;

  assign bus.out0_valid = nonempty && !head[32];
  assign bus.out1_valid = nonempty &&  head[32];
  assign bus.out0_data  = bus.out0_valid ? head[31:0] : 32'h0;
  assign bus.out1_data  = bus.out1_valid ? head[31:0] : 32'h0;

  assign pop0 = bus.out0_valid && bus.out0_ready;
  assign pop1 = bus.out1_valid && bus.out1_ready;
  assign pop  = pop0 || pop1;

  // Storage needs no reset. Entries are only observed while count covers
  // them, and reset clears count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {bus.in_sel, bus.in_data};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // The counters are free-running and wrap silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (pop0) cnt0 <= cnt0 + CNT_W'(1);
      if (pop1) cnt1 <= cnt1 + CNT_W'(1);
    end
  end
endmodule
